key_conditioner: RTL and testbench

//  Per-channel input conditioner for drum/pad keys: 2-FF synchroniser, counter-based

---
 rtl/key_conditioner_if.sv | 33 +++
 rtl/key_conditioner.sv | 165 ++++++++++++++++
 tb/tb_key_conditioner.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/key_conditioner_if.sv
// Key conditioner bus: raw key inputs and frame strobe in, conditioned key
// events out. The board/game side uses master, the conditioner uses slave.
interface key_conditioner_if #(
  parameter int CH = 4
) ();
  logic [CH-1:0] key_in;
  logic          frame_clr;
  logic [CH-1:0] key_level;
  logic [CH-1:0] key_press;
  logic [CH-1:0] key_release;
  logic [CH-1:0] key_latched;
  logic [CH-1:0] key_repeat;

  modport master (
    output key_in,
    output frame_clr,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_latched,
    input  key_repeat
  );

  modport slave (
    input  key_in,
    input  frame_clr,
    output key_level,
    output key_press,
    output key_release,
    output key_latched,
    output key_repeat
  );
endinterface

// File: rtl/key_conditioner.sv
// Per-channel key conditioner: 2-FF synchroniser, two-edge counter debounce,
// press/release pulses, per-frame sticky press flag and hold-to-repeat pulses.
module key_conditioner #(
  parameter int CH            = 4,
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  key_conditioner_if.slave bus
);

  localparam int CW   = $clog2(DB_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST   = RW'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
  localparam logic [RW-1:0] RP_LAST   = RW'(REPEAT_PERIOD - 1);
  localparam logic          REPEAT_EN = (REPEAT_DELAY > 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  logic [CH-1:0] r_s1;
  logic [CH-1:0] r_s2;
  logic [CH-1:0] r_level;
  logic [CH-1:0] r_press;
  logic [CH-1:0] r_release;
  logic [CH-1:0] r_latched;
  logic [CH-1:0] r_repeat;
  logic [CW-1:0] r_cnt [CH];
  logic [RW-1:0] r_rcnt [CH];
  state_e        r_state [CH];

  logic [CW-1:0] w_cnt_nxt [CH];
  logic [CH-1:0] w_level_nxt;
  logic [CH-1:0] w_rise;
  logic [CH-1:0] w_fall;
  logic [RW-1:0] w_rcnt_nxt [CH];
  state_e        w_state_nxt [CH];
  logic [CH-1:0] w_repeat_nxt;

  // Debounce: the level only flips after DB_CYCLES consecutive differing samples.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      w_cnt_nxt[i]   = '0;
      w_level_nxt[i] = r_level[i];
      w_rise[i]      = 1'b0;
      w_fall[i]      = 1'b0;
      if (r_s2[i] == r_level[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] >= DB_LAST) begin
        w_level_nxt[i] = r_s2[i];
        w_rise[i]      = r_s2[i];
        w_fall[i]      = ~r_s2[i];
        w_cnt_nxt[i]   = '0;
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + CW'(1);
      end
    end
  end

  // Repeat FSM next state; a release overrides everything so no pulse lands on it.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      w_state_nxt[i]  = r_state[i];
      w_rcnt_nxt[i]   = r_rcnt[i];
      w_repeat_nxt[i] = 1'b0;
      if (!REPEAT_EN) begin
        w_state_nxt[i] = ST_IDLE;
        w_rcnt_nxt[i]  = '0;
      end else if (w_fall[i]) begin
        w_state_nxt[i] = ST_IDLE;
        w_rcnt_nxt[i]  = '0;
      end else begin
        case (r_state[i])
          ST_IDLE: begin
            w_rcnt_nxt[i] = '0;
            if (w_rise[i]) begin
              w_state_nxt[i] = ST_HOLD;
            end else begin
              w_state_nxt[i] = ST_IDLE;
            end
          end
          ST_HOLD: begin
            if (r_rcnt[i] == RD_LAST) begin
              w_repeat_nxt[i] = 1'b1;
              w_state_nxt[i]  = ST_REPEAT;
              w_rcnt_nxt[i]   = '0;
            end else begin
              w_rcnt_nxt[i] = r_rcnt[i] + RW'(1);
            end
          end
          ST_REPEAT: begin
            if (r_rcnt[i] == RP_LAST) begin
              w_repeat_nxt[i] = 1'b1;
              w_rcnt_nxt[i]   = '0;
            end else begin
              w_rcnt_nxt[i] = r_rcnt[i] + RW'(1);
            end
          end
          default: begin
            w_state_nxt[i] = ST_IDLE;
            w_rcnt_nxt[i]  = '0;
          end
        endcase
      end
    end
  end

  // Synchroniser, debounce counters and registered key event outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_latched <= '0;
      r_repeat  <= '0;
      for (int i = 0; i < CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1      <= bus.key_in;
      r_s2      <= r_s1;
      r_level   <= w_level_nxt;
      r_press   <= w_rise;
      r_release <= w_fall;
      // A press in the frame_clr cycle must survive, so set dominates clear.
      r_latched <= w_rise | (r_latched & ~{CH{bus.frame_clr}});
      r_repeat  <= w_repeat_nxt;
      for (int i = 0; i < CH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // Repeat FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        r_state[i] <= ST_IDLE;
        r_rcnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_rcnt[i]  <= w_rcnt_nxt[i];
      end
    end
  end

  assign bus.key_level   = r_level;
  assign bus.key_press   = r_press;
  assign bus.key_release = r_release;
  assign bus.key_latched = r_latched;
  assign bus.key_repeat  = r_repeat;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: a sample-history reference model pushes
// expected outputs per cycle; a monitor pops and compares after each clock edge.
module tb_key_conditioner;
  localparam int CH = 4;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic clk;
  logic rst_n;

  key_conditioner_if #(.CH(CH)) bus ();

  key_conditioner #(
    .CH(CH), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [CH-1:0] level;
    logic [CH-1:0] press;
    logic [CH-1:0] rel;
    logic [CH-1:0] latched;
    logic [CH-1:0] rpt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   press_cnt [CH];
  int   rel_cnt [CH];
  int   rpt_cnt [CH];

  // reference model state: input delay line, per-channel sample history, press time
  logic [CH-1:0] m_d1, m_d2, m_level, m_latched;
  logic [DB-1:0] m_hist [CH];
  int            m_nsamp [CH];
  int            m_press_t [CH];
  int            m_step;

  task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_d1      = '0;
    m_d2      = '0;
    m_level   = '0;
    m_latched = '0;
    m_step    = 0;
    for (int c = 0; c < CH; c++) begin
      m_hist[c]    = '0;
      m_nsamp[c]   = 0;
      m_press_t[c] = 0;
    end
  endtask

  // One clock edge of the spec: level flips once the last DB synchronised samples
  // all disagree with it; repeats fall at press+RD, then every RP, while held.
  task automatic model_step(input logic [CH-1:0] k, input logic fc);
    logic [CH-1:0] smp;
    logic [DB-1:0] other;
    exp_t e;
    int t;
    smp  = m_d2;
    m_d2 = m_d1;
    m_d1 = k;
    m_step++;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      m_hist[c] = {m_hist[c][DB-2:0], smp[c]};
      if (m_nsamp[c] < DB) m_nsamp[c]++;
      other = m_level[c] ? {DB{1'b0}} : {DB{1'b1}};
      if (m_nsamp[c] >= DB && m_hist[c] == other) begin
        m_level[c] = ~m_level[c];
        if (m_level[c]) begin
          e.press[c]   = 1'b1;
          m_press_t[c] = m_step;
        end else begin
          e.rel[c] = 1'b1;
        end
      end else if (m_level[c]) begin
        t = m_step - m_press_t[c];
        e.rpt[c] = (t >= RD) && (((t - RD) % RP) == 0);
      end
      m_latched[c] = e.press[c] | (m_latched[c] & ~fc);
    end
    e.level   = m_level;
    e.latched = m_latched;
    exp_q.push_back(e);
  endtask

  // Called at a negedge: drive inputs for the coming edge, record the expectation.
  task automatic step(input logic [CH-1:0] k, input logic fc);
    bus.key_in    = k;
    bus.frame_clr = fc;
    model_step(k, fc);
    @(negedge clk);
  endtask

  task automatic cyc(input logic [CH-1:0] k, input logic fc, input int n);
    for (int j = 0; j < n; j++) step(k, fc);
  endtask

  task automatic hold_reset(input int n);
    rst_n = 1'b0;
    #1;
    chk("rst_level", bus.key_level, '0);
    chk("rst_press", bus.key_press, '0);
    chk("rst_release", bus.key_release, '0);
    chk("rst_latched", bus.key_latched, '0);
    chk("rst_repeat", bus.key_repeat, '0);
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: after each edge compare DUT outputs with the oldest expectation.
  initial begin
    exp_t e;
    for (int c = 0; c < CH; c++) begin
      press_cnt[c] = 0;
      rel_cnt[c]   = 0;
      rpt_cnt[c]   = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) begin
        press_cnt[c] += int'(bus.key_press[c]);
        rel_cnt[c]   += int'(bus.key_release[c]);
        rpt_cnt[c]   += int'(bus.key_repeat[c]);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("level", bus.key_level, e.level);
        chk("press", bus.key_press, e.press);
        chk("release", bus.key_release, e.rel);
        chk("latched", bus.key_latched, e.latched);
        chk("repeat", bus.key_repeat, e.rpt);
      end
    end
  end

  initial begin
    int p0, p1, p3, r0, r1, rl1;
    logic [CH-1:0] cur;
    rst_n         = 1'b0;
    bus.key_in    = '0;
    bus.frame_clr = 1'b0;
    repeat (2) @(negedge clk);
    hold_reset(2);

    // 1: single press on ch0, short hold
    r0 = rpt_cnt[0];
    cyc(4'b0001, 1'b0, 10);
    cyc(4'b0000, 1'b0, 10);
    chk_int("t1_press0", press_cnt[0], 1);
    chk_int("t1_norepeat0", rpt_cnt[0] - r0, 0);

    // 2: ch1 bounce 3 high / 1 low x5, steady high, 1-cycle low glitch
    p1 = press_cnt[1];
    rl1 = rel_cnt[1];
    for (int r = 0; r < 5; r++) begin
      cyc(4'b0010, 1'b0, 3);
      cyc(4'b0000, 1'b0, 1);
    end
    cyc(4'b0010, 1'b0, 12);
    cyc(4'b0000, 1'b0, 1);
    cyc(4'b0010, 1'b0, 6);
    chk_int("t2_one_press1", press_cnt[1] - p1, 1);
    chk_int("t2_no_release1", rel_cnt[1] - rl1, 0);
    cyc(4'b0000, 1'b0, 10);

    // 3: frame_clr coinciding with press, then alone, then latched across release
    cyc(4'b0100, 1'b0, 5);
    cyc(4'b0100, 1'b1, 1);
    cyc(4'b0100, 1'b1, 1);
    cyc(4'b0100, 1'b0, 3);
    cyc(4'b0000, 1'b0, 10);
    cyc(4'b0100, 1'b0, 10);
    cyc(4'b0000, 1'b0, 12);

    // 4: long hold on ch0; the +60 repeat coincides with release and is suppressed
    r0 = rpt_cnt[0];
    cyc(4'b0001, 1'b0, 60);
    cyc(4'b0000, 1'b0, 30);
    chk_int("t4_repeats0", rpt_cnt[0] - r0, 5);

    // 5: ch0 and ch3 pressed together while ch1 bounces
    p0 = press_cnt[0];
    p1 = press_cnt[1];
    p3 = press_cnt[3];
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 4; j++) step((j < 3) ? 4'b1011 : 4'b1001, 1'b0);
    end
    cyc(4'b1011, 1'b0, 12);
    cyc(4'b0000, 1'b0, 12);
    chk_int("t5_press0", press_cnt[0] - p0, 1);
    chk_int("t5_press1", press_cnt[1] - p1, 1);
    chk_int("t5_press3", press_cnt[3] - p3, 1);

    // 6: reset in the middle of a HOLD with the key still down
    p1 = press_cnt[1];
    r1 = rpt_cnt[1];
    cyc(4'b0010, 1'b0, 15);
    hold_reset(3);
    cyc(4'b0010, 1'b0, 40);
    cyc(4'b0000, 1'b0, 12);
    chk_int("t6_press1", press_cnt[1] - p1, 2);
    chk_int("t6_repeats1", rpt_cnt[1] - r1, 3);

    // random phase: bursty toggles, random frame strobes, rare resets
    cur = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 99) < 3) cur[c] = ~cur[c];
      end
      if ($urandom_range(0, 999) == 0) hold_reset(2);
      step(cur, ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
    end
    cyc(4'b0000, 1'b0, 12);
    repeat (2) @(negedge clk);
    chk_int("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
